stream_compare_scan: RTL and testbench

STREAM_COMPARE_SCAN -- requirements
Module: stream_compare_scan

---
 rtl/stream_compare_scan_pkg.sv | 37 +++
 rtl/stream_compare_scan_next_link.sv | 24 ++
 rtl/stream_compare_scan.sv | 150 +++++++++++++++
 tb/tb_stream_compare_scan.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_compare_scan_pkg.sv
// Shared types and helpers for the stream compare scan controller.
// The scan state enum, the link-count ceiling and a saturating adder live here.
package stream_compare_scan_pkg;

    // Largest number of links the comparator mask can address.
    localparam int MAX_LINKS = 16;

    // Index width needed to name any link up to MAX_LINKS.
    localparam int LINK_IDX_W = $clog2(MAX_LINKS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        CLEAR  = 3'd2,
        SETTLE = 3'd3,
        RUN    = 3'd4,
        RECORD = 3'd5,
        DONE   = 3'd6
    } state_t;

    // Adds two unsigned values and clamps the result to all-ones of 'width' bits.
    // Operands are zero-extended to 64 bits by the caller; width must be 1..64.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int          width);
        logic [64:0] sum;
        logic [64:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (65'd1 << width) - 65'd1;
        if (sum > max_val) begin
            sat_add = max_val[63:0];
        end else begin
            sat_add = sum[63:0];
        end
    endfunction

endpackage

// File: rtl/stream_compare_scan_next_link.sv
// Lowest-set-bit finder: picks the lowest-index link still waiting to be scanned.
module scan_next_link
    import stream_compare_scan_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]            remaining,
    output logic [LINK_IDX_W-1:0]   index,
    output logic                    valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (remaining[i]) begin
                index = LINK_IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_compare_scan.sv
// Stream compare scan controller.
// Walks the enabled links one at a time: clears the comparator, lets it settle,
// waits for 'window' words, then records the link's error count.
// Optional feature macro: SCAN_TIMEOUT_EN adds a per-link stall timeout in RUN.
// scan_state exposes the FSM state for observation.
module stream_compare_scan
    import stream_compare_scan_pkg::*;
#(
    parameter int NLINKS         = 8,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [CNT_W-1:0]      window,
    input  logic [NLINKS-1:0]     link_enable,
    input  logic [CNT_W-1:0]      cmp_word_count,
    input  logic [CNT_W-1:0]      cmp_err_count,
    output logic                  cmp_reset,
    output logic [MAX_LINKS-1:0]  cmp_active_links,
    output logic                  cmp_active_links_map,
    output logic                  busy,
    output logic                  done,
    output logic [NLINKS-1:0]     link_fail,
    output logic [CNT_W-1:0]      err_total,
    output logic [NLINKS-1:0]     link_timeout,
    output logic [2:0]            scan_state
);

    state_t                 state;
    logic [CNT_W-1:0]       window_q;
    // Shadow of link_enable; bits are consumed as each link is scanned.
    logic [NLINKS-1:0]      remaining_q;
    logic [LINK_IDX_W-1:0]  next_idx;
    logic                   next_valid;
    logic [NLINKS-1:0]      sel_mask;

    assign cmp_active_links_map = 1'b1;
    assign scan_state           = state;
    // The registered one-hot comparator mask doubles as the current-link mask.
    assign sel_mask             = cmp_active_links[NLINKS-1:0];

`ifdef SCAN_TIMEOUT_EN
    logic [31:0]            stall_cnt;
    logic [CNT_W-1:0]       last_wc;
    logic [NLINKS-1:0]      link_timeout_q;
    assign link_timeout = link_timeout_q;
`else
    assign link_timeout = '0;
`endif

    scan_next_link #(.N(NLINKS)) u_next_link (
        .remaining (remaining_q),
        .index     (next_idx),
        .valid     (next_valid)
    );

    // Scan sequencer with registered outputs; results persist until the next accepted start.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            cmp_reset        <= 1'b0;
            cmp_active_links <= '0;
            link_fail        <= '0;
            err_total        <= '0;
            window_q         <= '0;
            remaining_q      <= '0;
`ifdef SCAN_TIMEOUT_EN
            stall_cnt        <= '0;
            last_wc          <= '0;
            link_timeout_q   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        window_q    <= window;
                        remaining_q <= link_enable;
                        link_fail   <= '0;
                        err_total   <= '0;
`ifdef SCAN_TIMEOUT_EN
                        link_timeout_q <= '0;
`endif
                        busy        <= 1'b1;
                        state       <= SELECT;
                    end
                end
                SELECT: begin
                    if (next_valid) begin
                        cmp_active_links <= MAX_LINKS'(1) << next_idx;
                        remaining_q      <= remaining_q & ~(NLINKS'(1) << next_idx);
                        cmp_reset        <= 1'b1;
                        state            <= CLEAR;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                CLEAR: begin
                    cmp_reset <= 1'b0;
                    state     <= SETTLE;
                end
                SETTLE: begin
                    // Counts seen before this cycle may predate the clear; RUN starts fresh.
`ifdef SCAN_TIMEOUT_EN
                    stall_cnt <= '0;
                    last_wc   <= cmp_word_count;
`endif
                    state <= RUN;
                end
                RUN: begin
                    if (cmp_word_count >= window_q) begin
                        state <= RECORD;
                    end
`ifdef SCAN_TIMEOUT_EN
                    else if (cmp_word_count != last_wc) begin
                        last_wc   <= cmp_word_count;
                        stall_cnt <= '0;
                    end else if (stall_cnt >= 32'(TIMEOUT_CYCLES - 1)) begin
                        link_timeout_q <= link_timeout_q | sel_mask;
                        link_fail      <= link_fail | sel_mask;
                        state          <= SELECT;
                    end else begin
                        stall_cnt <= stall_cnt + 32'd1;
                    end
`endif
                end
                RECORD: begin
                    link_fail <= link_fail | (sel_mask & {NLINKS{|cmp_err_count}});
                    err_total <= CNT_W'(sat_add(64'(err_total), 64'(cmp_err_count), CNT_W));
                    state     <= SELECT;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_compare_scan.sv
// Bench for stream_compare_scan with NLINKS=4 and a behavioural comparator.
// Stimulus pushes expected link order and scan results; a monitor pops them on
// each cmp_reset / done pulse. Build with SCAN_TIMEOUT_EN to add the stall case.
module tb_stream_compare_scan;

    localparam int NL = 4;
    localparam int CW = 32;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    logic            start       = 1'b0;
    logic [CW-1:0]   window      = '0;
    logic [NL-1:0]   link_enable = '0;
    logic [CW-1:0]   cmp_word_count;
    logic [CW-1:0]   cmp_err_count;
    logic            cmp_reset;
    logic [15:0]     cmp_active_links;
    logic            cmp_active_links_map;
    logic            busy;
    logic            done;
    logic [NL-1:0]   link_fail;
    logic [CW-1:0]   err_total;
    logic [NL-1:0]   link_timeout;
    logic [2:0]      scan_state;

    stream_compare_scan #(.NLINKS(NL), .CNT_W(CW), .TIMEOUT_CYCLES(50)) dut (
        .clk                  (clk),
        .aresetn              (aresetn),
        .start                (start),
        .window               (window),
        .link_enable          (link_enable),
        .cmp_word_count       (cmp_word_count),
        .cmp_err_count        (cmp_err_count),
        .cmp_reset            (cmp_reset),
        .cmp_active_links     (cmp_active_links),
        .cmp_active_links_map (cmp_active_links_map),
        .busy                 (busy),
        .done                 (done),
        .link_fail            (link_fail),
        .err_total            (err_total),
        .link_timeout         (link_timeout),
        .scan_state           (scan_state)
    );

    // ---------------- comparator model ----------------
    logic [CW-1:0] err_cfg [NL];
    logic          freeze_link1 = 1'b0;

    function automatic int onehot_idx(input logic [15:0] m);
        int r;
        r = 0;
        for (int i = 0; i < NL; i++) if (m[i]) r = i;
        return r;
    endfunction

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cmp_word_count <= 32'hDEAD_0000;
            cmp_err_count  <= 32'h0000_0055;
        end else if (cmp_reset) begin
            cmp_word_count <= '0;
            cmp_err_count  <= '0;
        end else begin
            if (!(freeze_link1 && cmp_active_links == 16'h0002))
                cmp_word_count <= cmp_word_count + 32'd1;
            cmp_err_count <= err_cfg[onehot_idx(cmp_active_links)];
        end
    end

    // ---------------- scoreboard ----------------
    logic [15:0] exp_sel_q[$];
    logic [39:0] exp_res_q[$];   // {link_fail, err_total, link_timeout}
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic done_prev = 1'b0;
    logic creset_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT selects a link or finishes a scan.
    always @(negedge clk) begin
        logic [39:0] r;
        if (aresetn) begin
            if (cmp_reset) begin
                if (exp_sel_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sel_unexpected: got %0h expected none", cmp_active_links);
                end else begin
                    check("sel_order", 64'(cmp_active_links), 64'(exp_sel_q.pop_front()));
                end
                check("clear_width", 64'(creset_prev), 64'd0);
            end
            if (done) begin
                done_cnt++;
                if (exp_res_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_unexpected: got done=1 expected none");
                end else begin
                    r = exp_res_q.pop_front();
                    check("link_fail", 64'(link_fail), 64'(r[39:36]));
                    check("err_total", 64'(err_total), 64'(r[35:4]));
                    check("link_timeout", 64'(link_timeout), 64'(r[3:0]));
                end
                check("done_width", 64'(done_prev), 64'd0);
            end
        end
        done_prev   = done;
        creset_prev = cmp_reset;
    end

    // ---------------- driver tasks ----------------
    task automatic issue_start(input logic [NL-1:0] en, input logic [CW-1:0] win);
        @(posedge clk); #1;
        link_enable = en;
        window      = win;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            if (done_cnt > base) break;
        end
        check("done_seen", 64'(done_cnt > base), 64'd1);
    endtask

    task automatic push_sel(input logic [NL-1:0] en);
        for (int i = 0; i < NL; i++) if (en[i]) exp_sel_q.push_back(16'd1 << i);
    endtask

    task automatic run_scan(input logic [NL-1:0] en, input logic [CW-1:0] win,
                            input logic [NL-1:0] e_fail, input logic [CW-1:0] e_err,
                            input logic [NL-1:0] e_to);
        int base;
        base = done_cnt;
        push_sel(en);
        exp_res_q.push_back({e_fail, e_err, e_to});
        issue_start(en, win);
        wait_done(base, 3000);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        for (int i = 0; i < NL; i++) err_cfg[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cmp_reset", 64'(cmp_reset), 64'd0);
        check("rst_active", 64'(cmp_active_links), 64'd0);
        check("rst_link_fail", 64'(link_fail), 64'd0);
        check("rst_err_total", 64'(err_total), 64'd0);
        check("rst_timeout", 64'(link_timeout), 64'd0);
        check("map_const", 64'(cmp_active_links_map), 64'd1);
        aresetn = 1'b1;

        // Two links, no errors.
        run_scan(4'b0101, 32'd10, 4'b0000, 32'd0, 4'b0000);
        check("active_hold_idle", 64'(cmp_active_links), 64'h4);

        // All links, link 2 sees 3 errors; results must hold afterwards.
        err_cfg[2] = 32'd3;
        run_scan(4'b1111, 32'd100, 4'b0100, 32'd3, 4'b0000);
        repeat (6) @(posedge clk);
        #1;
        check("hold_link_fail", 64'(link_fail), 64'h4);
        check("hold_err_total", 64'(err_total), 64'd3);

        // Sum just below all-ones, no saturation.
        err_cfg[0] = 32'h7FFF_FFF8; err_cfg[1] = 32'h7FFF_FFF8; err_cfg[2] = '0;
        run_scan(4'b0011, 32'd5, 4'b0011, 32'hFFFF_FFF0, 4'b0000);
        // FFFF_FFF0 reached after two links, third link pushes past all-ones.
        err_cfg[2] = 32'h20;
        run_scan(4'b0111, 32'd5, 4'b0111, 32'hFFFF_FFFF, 4'b0000);
        // Two links of 0x8000_0000 each overflow exactly by one.
        err_cfg[0] = 32'h8000_0000; err_cfg[1] = 32'h8000_0000; err_cfg[2] = '0;
        run_scan(4'b0011, 32'd5, 4'b0011, 32'hFFFF_FFFF, 4'b0000);

        // No links enabled: done two cycles after start.
        exp_res_q.push_back({4'b0000, 32'd0, 4'b0000});
        base = done_cnt;
        @(posedge clk); #1;
        link_enable = 4'b0000; window = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("empty_busy", 64'(busy), 64'd1);
        check("empty_done_early", 64'(done), 64'd0);
        @(posedge clk); #1;
        check("empty_done_at_2", 64'(done), 64'd1);
        wait_done(base, 10);

        // Window 0: a single link records its live count immediately.
        for (int i = 0; i < NL; i++) err_cfg[i] = '0;
        err_cfg[3] = 32'd7;
        run_scan(4'b1000, 32'd0, 4'b1000, 32'd7, 4'b0000);

        // Extra start mid-RUN is ignored.
        err_cfg[3] = '0; err_cfg[1] = 32'd2;
        base = done_cnt;
        push_sel(4'b0110);
        exp_res_q.push_back({4'b0010, 32'd2, 4'b0000});
        issue_start(4'b0110, 32'd20);
        repeat (8) @(posedge clk);
        #1;
        link_enable = 4'b1111; window = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(base, 3000);
        repeat (10) @(posedge clk);
        check("single_done", 64'(done_cnt), 64'(base + 1));

        // Reset pulse during RUN of link 1 aborts with no done.
        err_cfg[1] = '0;
        push_sel(4'b0011);
        issue_start(4'b0011, 32'd30);
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            if (cmp_active_links == 16'h2 && scan_state == 3'd4) break;
        end
        check("reached_run_link1", 64'(scan_state), 64'd4);
        repeat (3) @(posedge clk);
        #2;
        aresetn = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_cmp_reset", 64'(cmp_reset), 64'd0);
        check("abort_active", 64'(cmp_active_links), 64'd0);
        check("abort_state", 64'(scan_state), 64'd0);
        check("abort_err_total", 64'(err_total), 64'd0);
        check("abort_link_fail", 64'(link_fail), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        base = done_cnt;
        repeat (15) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt), 64'(base));
        check("abort_stays_idle", 64'(busy), 64'd0);

        // Fresh scan after reset completes normally.
        err_cfg[0] = 32'd1;
        run_scan(4'b0001, 32'd4, 4'b0001, 32'd1, 4'b0000);
        err_cfg[0] = '0;

`ifdef SCAN_TIMEOUT_EN
        // Link 1 word count frozen: stall timeout, scan continues to link 2.
        freeze_link1 = 1'b1;
        run_scan(4'b0110, 32'd10, 4'b0010, 32'd0, 4'b0010);
        freeze_link1 = 1'b0;
`endif

        repeat (5) @(posedge clk);
        check("sel_queue_empty", 64'(exp_sel_q.size()), 64'd0);
        check("res_queue_empty", 64'(exp_res_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
